// File: rtl/wb_pkg.sv
// Shared types and constants for the register write-back controller.
package wb_pkg;

    // Register 0 is hard-wired; writes to it are consumed but never committed.
    localparam int REG_ZERO = 0;

    // Default geometry used by the load entry type below.
    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    // Origin of the value currently held in the write-port register.
    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_LOAD = 2'd2
    } wb_src_e;

    // One buffered load result.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] dest;
        logic [WB_DATA_W-1:0] data;
    } wb_load_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Small synchronous FIFO that buffers accepted load results until the write
// port is free. Push is ignored when full and pop is ignored when empty.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [ADDR_WIDTH-1:0] i_push_dest,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH-1:0] o_head_dest,
    output logic [DATA_WIDTH-1:0] o_head_data
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_push;
    logic               w_do_pop;
    logic [ENTRY_W-1:0] w_head;

    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign w_do_push   = i_push && !o_full;
    assign w_do_pop    = i_pop && !o_empty;
    assign w_head      = r_mem[r_rd_ptr];
    assign o_head_dest = w_head[ENTRY_W-1:DATA_WIDTH];
    assign o_head_data = w_head[DATA_WIDTH-1:0];

    // Storage array: written on accepted push only, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= {i_push_dest, i_push_data};
        end
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register write-back controller: arbitrates ALU results (priority) against
// buffered load results onto the single register-file write port, and tracks
// registers with outstanding loads in a busy scoreboard.
module reg_writeback_ctrl
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 5,
    parameter int LOAD_FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       aluValid,
    input  logic [ADDR_WIDTH-1:0]      aluDest,
    input  logic [DATA_WIDTH-1:0]      aluData,
    input  logic                       loadValid,
    output logic                       loadReady,
    input  logic [ADDR_WIDTH-1:0]      loadDest,
    input  logic [DATA_WIDTH-1:0]      loadData,
    input  logic                       issueLoad,
    input  logic [ADDR_WIDTH-1:0]      issueDest,
    output logic [2**ADDR_WIDTH-1:0]   busyMask,
    output logic                       regWriteControl,
    output logic [ADDR_WIDTH-1:0]      writeRegAddress,
    output logic [DATA_WIDTH-1:0]      writeRegData,
    output logic                       wawError
);

    localparam int NREGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_head_dest;
    logic [DATA_WIDTH-1:0] w_head_data;

    wb_src_e               w_sel_src;
    logic [ADDR_WIDTH-1:0] w_sel_dest;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [NREGS-1:0]      w_busy_next;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    wb_src_e               r_src;
    logic [NREGS-1:0]      r_busy;
    logic                  r_waw;

    // Ready depends only on occupancy; a full FIFO refuses even if it pops this cycle.
    assign loadReady = !w_full;
    assign w_push    = loadValid && loadReady;
    assign w_pop     = !aluValid && !w_empty;

    wb_load_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (LOAD_FIFO_DEPTH)
    ) u_load_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_dest (loadDest),
        .i_push_data (loadData),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_dest (w_head_dest),
        .o_head_data (w_head_data)
    );

    // Source select: ALU always wins, FIFO head only when the ALU is idle.
    always_comb begin
        w_sel_src  = WB_SRC_NONE;
        w_sel_dest = w_head_dest;
        w_sel_data = w_head_data;
        if (aluValid) begin
            w_sel_src  = WB_SRC_ALU;
            w_sel_dest = aluDest;
            w_sel_data = aluData;
        end else if (!w_empty) begin
            w_sel_src  = WB_SRC_LOAD;
        end
    end

    // Write-port register; register 0 targets are consumed without enabling the write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_src  <= WB_SRC_NONE;
        end else if (w_sel_src != WB_SRC_NONE) begin
            r_we   <= (w_sel_dest != ZERO_ADDR);
            r_addr <= w_sel_dest;
            r_data <= w_sel_data;
            r_src  <= w_sel_src;
        end else begin
            r_we   <= 1'b0;
            r_src  <= WB_SRC_NONE;
        end
    end

    // Scoreboard next state: clear on committed load write, then set on issue so set wins.
    always_comb begin
        w_busy_next = r_busy;
        if (r_we && (r_src == WB_SRC_LOAD)) begin
            w_busy_next[r_addr] = 1'b0;
        end
        if (issueLoad && (issueDest != ZERO_ADDR)) begin
            w_busy_next[issueDest] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Scoreboard and sticky write-after-write flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_waw  <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (aluValid && (aluDest != ZERO_ADDR) && r_busy[aluDest]) begin
                r_waw <= 1'b1;
            end
        end
    end

    assign regWriteControl = r_we;
    assign writeRegAddress = r_addr;
    assign writeRegData    = r_data;
    assign busyMask        = r_busy;
    assign wawError        = r_waw;

endmodule
